pluto_event_reporter: RTL and testbench



---
 rtl/pluto_event_reporter.sv | 154 +++++++++++++++
 tb/tb_pluto_event_reporter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pluto_event_reporter.sv
`default_nettype none
// ============================================================================
// Module      : pluto_event_reporter
// Description : Queues non-zero pluto/flag events in a small FIFO and sends
//               each one as an 11-bit serial frame with a ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pluto_event_reporter #(
    parameter int DEPTH = 4
) (
    input  logic                   pclk,
    input  logic                   prst,
    input  logic                   pevt_vld,
    input  logic [5:0]             ppluto,
    input  logic                   pverr_f,
    input  logic                   pkbg_f,
    input  logic                   porwd_f,
    input  logic                   psdo_rdy,
    output logic                   psdo,
    output logic                   psdo_vld,
    output logic [$clog2(DEPTH):0] pfifo_cnt,
    output logic                   povf,
    output logic                   pbusy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    LAST_BIT = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   sh_q, sh_d;
    logic [3:0]    bit_q, bit_d;
    logic          load_q, load_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;

    logic [8:0]    w_payload;
    logic [9:0]    w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_wr;
    logic          w_full;

    assign w_payload = {porwd_f, pkbg_f, pverr_f, ppluto};
    assign w_push    = pevt_vld && (w_payload != 9'd0);
    assign w_full    = (cnt_q == FULL_CNT);
    assign w_head    = mem_q[rd_ptr_q];

    // A popped entry sits pre-loaded for one IDLE cycle (load_q) before
    // shifting starts; popping at the last bit keeps a full FIFO able to
    // accept a push at that same edge.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        load_d  = load_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_q) begin
                    state_d = ST_SHIFT;
                    bit_d   = 4'd0;
                    load_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    w_pop  = 1'b1;
                    sh_d   = {w_head, 1'b0};
                    bit_d  = 4'd0;
                    load_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (psdo_rdy) begin
                    sh_d  = {1'b1, sh_q[10:1]};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        if (cnt_q != '0) begin
                            w_pop  = 1'b1;
                            sh_d   = {w_head, 1'b0};
                            bit_d  = 4'd0;
                            load_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                load_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wr     = w_push && (!w_full || w_pop);
        ovf_d    = ovf_q || (w_push && w_full && !w_pop);
        wr_ptr_d = w_wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_wr && !w_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!w_wr && w_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        busy_d = (state_d == ST_SHIFT) || load_d || (cnt_d != '0);
    end

    always_ff @(posedge pclk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= {^w_payload, w_payload};
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sh_q     <= '1;
            bit_q    <= 4'd0;
            load_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            load_q   <= load_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
        end
    end

    assign psdo_vld  = (state_q == ST_SHIFT);
    assign psdo      = psdo_vld ? sh_q[0] : 1'b1;
    assign pfifo_cnt = cnt_q;
    assign povf      = ovf_q;
    assign pbusy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pluto_event_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pluto_event_reporter
// Description : Directed and random stimulus against a queue-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pluto_event_reporter;

    localparam int DEPTH = 4;

    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic       pevt_vld = 1'b0;
    logic [5:0] ppluto = 6'd0;
    logic       pverr_f = 1'b0;
    logic       pkbg_f = 1'b0;
    logic       porwd_f = 1'b0;
    logic       psdo_rdy = 1'b0;
    logic       psdo;
    logic       psdo_vld;
    logic [2:0] pfifo_cnt;
    logic       povf;
    logic       pbusy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending events, the frame currently on the wire as a
    // list of remaining bits, and one popped frame waiting to start.
    logic [9:0] fifo_m [$];
    bit         fr_m [$];
    bit         pend_m;
    logic [9:0] pend_w;
    bit         ovf_m;
    bit         cap_q [$];

    pluto_event_reporter #(.DEPTH(DEPTH)) dut (
        .pclk      (pclk),
        .prst      (prst),
        .pevt_vld  (pevt_vld),
        .ppluto    (ppluto),
        .pverr_f   (pverr_f),
        .pkbg_f    (pkbg_f),
        .porwd_f   (porwd_f),
        .psdo_rdy  (psdo_rdy),
        .psdo      (psdo),
        .psdo_vld  (psdo_vld),
        .pfifo_cnt (pfifo_cnt),
        .povf      (povf),
        .pbusy     (pbusy)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [8:0] p;
        bit         busy_frame;
        bit         old_pend;
        bit         do_pop;
        bit         full;
        if (prst) begin
            fifo_m.delete();
            fr_m.delete();
            pend_m = 0;
            ovf_m  = 0;
            return;
        end
        p          = {porwd_f, pkbg_f, pverr_f, ppluto};
        busy_frame = (fr_m.size() != 0);
        old_pend   = pend_m;
        do_pop     = 0;
        full       = (fifo_m.size() == DEPTH);
        if (busy_frame && psdo_rdy) begin
            void'(fr_m.pop_front());
            if (fr_m.size() == 0 && fifo_m.size() != 0) do_pop = 1;
        end else if (!busy_frame && !old_pend && fifo_m.size() != 0) begin
            do_pop = 1;
        end
        if (old_pend) begin
            fr_m.push_back(1'b0);
            for (int k = 0; k < 10; k++) fr_m.push_back(pend_w[k]);
            pend_m = 0;
        end
        if (do_pop) begin
            pend_w = fifo_m.pop_front();
            pend_m = 1;
        end
        if (pevt_vld && p != 9'd0) begin
            if (full && !do_pop) ovf_m = 1;
            else fifo_m.push_back({^p, p});
        end
    endtask

    task automatic compare();
        bit m_vld;
        m_vld = (fr_m.size() != 0);
        check_eq("psdo_vld", psdo_vld, m_vld);
        check_eq("psdo", psdo, m_vld ? fr_m[0] : 1'b1);
        check_eq("pfifo_cnt", pfifo_cnt, fifo_m.size());
        check_eq("povf", povf, ovf_m);
        check_eq("pbusy", pbusy, m_vld || pend_m || (fifo_m.size() != 0));
    endtask

    task automatic step();
        @(posedge pclk);
        if (psdo_vld && psdo_rdy) cap_q.push_back(psdo);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_evt(input logic [8:0] p);
        {porwd_f, pkbg_f, pverr_f, ppluto} = p;
        pevt_vld = 1'b1;
    endtask

    task automatic clr_evt();
        {porwd_f, pkbg_f, pverr_f, ppluto} = 9'd0;
        pevt_vld = 1'b0;
    endtask

    task automatic do_reset();
        clr_evt();
        psdo_rdy = 1'b0;
        prst = 1'b1;
        step();
        step();
        prst = 1'b0;
        cap_q.delete();
        check_eq("rst_psdo", psdo, 1'b1);
        check_eq("rst_vld", psdo_vld, 1'b0);
        check_eq("rst_cnt", pfifo_cnt, 3'd0);
        check_eq("rst_ovf", povf, 1'b0);
        check_eq("rst_busy", pbusy, 1'b0);
    endtask

    task automatic wait_vld(input int limit);
        for (int i = 0; i < limit && !psdo_vld; i++) step();
        if (!psdo_vld) check_eq("wait_vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int limit);
        psdo_rdy = 1'b1;
        for (int i = 0; i < limit && pbusy; i++) step();
        check_eq("drain_idle", pbusy, 1'b0);
    endtask

    task automatic check_frame(input int idx, input logic [8:0] exp_p);
        logic [8:0] p;
        if (cap_q.size() < (idx + 1) * 11) begin
            check_eq("frame_missing", cap_q.size(), (idx + 1) * 11);
            return;
        end
        check_eq("frame_start", cap_q[idx*11], 1'b0);
        for (int k = 0; k < 9; k++) p[k] = cap_q[idx*11 + 1 + k];
        check_eq("frame_payload", p, exp_p);
        check_eq("frame_parity", cap_q[idx*11 + 10], ^exp_p);
    endtask

    initial begin
        logic [10:0] exp_seq;
        logic [8:0]  ov_p [6];
        int          vcount;
        bit          prev;
        bit          held;
        int          vld_seen;

        pend_m = 0;
        ovf_m  = 0;
        pend_w = '0;
        exp_seq = 11'b100_0000_0010;
        ov_p[0] = 9'h001; ov_p[1] = 9'h002; ov_p[2] = 9'h004;
        ov_p[3] = 9'h008; ov_p[4] = 9'h010; ov_p[5] = 9'h020;

        // single event, ready always high
        do_reset();
        psdo_rdy = 1'b1;
        set_evt(9'h001);
        step();
        clr_evt();
        step();
        check_eq("lat_edge1_vld", psdo_vld, 1'b0);
        step();
        check_eq("lat_edge2_vld", psdo_vld, 1'b1);
        for (int i = 0; i < 12; i++) step();
        check_eq("single_len", cap_q.size(), 11);
        for (int k = 0; k < 11; k++) check_eq("single_bit", cap_q[k], exp_seq[k]);
        check_eq("single_busy", pbusy, 1'b0);

        // back-pressure: ready low on even valid cycles
        do_reset();
        set_evt(9'h001);
        step();
        clr_evt();
        wait_vld(10);
        vcount = 0;
        while (psdo_vld && vcount < 60) begin
            psdo_rdy = vcount[0];
            prev = psdo;
            held = !psdo_rdy;
            step();
            vcount++;
            if (held) check_eq("bp_stable", psdo, prev);
        end
        check_eq("bp_len", vcount, 22);
        for (int k = 0; k < 11; k++) check_eq("bp_bit", cap_q.size() > k ? cap_q[k] : 1'bx, exp_seq[k]);

        // overflow: frame stalled, five more pushes into a 4-deep FIFO
        do_reset();
        set_evt(ov_p[0]);
        step();
        clr_evt();
        wait_vld(10);
        for (int i = 1; i < 6; i++) begin
            set_evt(ov_p[i]);
            step();
        end
        clr_evt();
        check_eq("ovf_cnt", pfifo_cnt, 3'd4);
        check_eq("ovf_flag", povf, 1'b1);
        drain(400);
        check_eq("ovf_frames", cap_q.size(), 55);
        for (int i = 0; i < 5; i++) check_frame(i, ov_p[i]);
        check_eq("ovf_sticky", povf, 1'b1);

        // full FIFO, push lands on the frame-completing edge
        do_reset();
        set_evt(ov_p[0]);
        step();
        clr_evt();
        wait_vld(10);
        for (int i = 1; i < 5; i++) begin
            set_evt(ov_p[i]);
            step();
        end
        clr_evt();
        check_eq("fp_full", pfifo_cnt, 3'd4);
        psdo_rdy = 1'b1;
        for (int i = 0; i < 10; i++) step();
        set_evt(ov_p[5]);
        step();
        clr_evt();
        check_eq("fp_cnt", pfifo_cnt, 3'd4);
        check_eq("fp_ovf", povf, 1'b0);
        drain(400);

        // zero payload is ignored; ordering of two pushes
        do_reset();
        set_evt(9'h000);
        step();
        check_eq("zero_cnt", pfifo_cnt, 3'd0);
        set_evt(9'h020);
        step();
        set_evt(9'h100);
        step();
        clr_evt();
        drain(200);
        check_eq("ord_frames", cap_q.size(), 22);
        check_frame(0, 9'h020);
        check_frame(1, 9'h100);

        // reset in the middle of a frame
        do_reset();
        psdo_rdy = 1'b1;
        set_evt(9'h015);
        step();
        set_evt(9'h0aa);
        step();
        clr_evt();
        wait_vld(10);
        for (int i = 0; i < 20 && cap_q.size() < 5; i++) step();
        prst = 1'b1;
        step();
        check_eq("mid_psdo", psdo, 1'b1);
        check_eq("mid_vld", psdo_vld, 1'b0);
        check_eq("mid_cnt", pfifo_cnt, 3'd0);
        check_eq("mid_ovf", povf, 1'b0);
        prst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (psdo_vld) vld_seen++;
        end
        check_eq("mid_residual", vld_seen, 0);

        // random traffic with periodic ready stalls and rare resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            prst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 2) == 0)
                set_evt(($urandom_range(0, 4) == 0) ? 9'd0 : 9'($urandom));
            else
                clr_evt();
            psdo_rdy = ((i % 500) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
        end
        prst = 1'b0;
        clr_evt();
        drain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
